hazard_stall_ctrl: RTL and testbench

Pipeline interlock controller for the 5-stage core, paired with the forwarding unit. It handles the hazards that forwarding cannot cover:
- load-use dependencies, resolved with a one-cycle bubble;
- multi-cycle data-memory accesses, resolved with a full back-end freeze and a timeout watchdog;
- taken-branch redirects, resolved by flushing IF/ID and ID/EX.

It sits beside the ID/EX/MEM pipeline registers and drives their write-enable and flush controls.

---
 rtl/hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline interlock controller for the 5-stage core. It covers the hazards
//   the forwarding unit cannot resolve:
//     - load-use dependency     -> one-cycle bubble into ID/EX
//     - multi-cycle dmem access -> full back-end freeze with timeout watchdog
//     - taken branch/jump       -> flush IF/ID and ID/EX
//
// Parameters
//   WAIT_TIMEOUT  max consecutive MEM wait cycles before the sticky error (>=1)
//   CNT_W         performance counter width (present only with HAZARD_PERF_EN)
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   id_rs1/id_rs2                source registers of the instruction in ID
//   id_uses_rs1/id_uses_rs2      ID instruction really reads rs1/rs2
//   idex_rd, idex_memread        destination / load flag of the EX instruction
//   branch_taken                 EX resolved a taken branch/jump this cycle
//   dmem_req, dmem_ready         MEM-stage data memory handshake
//   pc_write, ifid_write         PC / IF-ID write enables
//   ifid_flush, idex_flush       zero IF/ID, load bubble into ID/EX
//   ex_hold                      hold ID/EX and EX/MEM
//   memwb_bubble                 write a bubble into MEM/WB
//   mem_err                      sticky memory timeout error
//   stall_cycles, flush_events   saturating perf counters (HAZARD_PERF_EN)
//
// Build option
//   HAZARD_PERF_EN  when defined, adds CNT_W and the two performance counters.

module hazard_stall_ctrl #(
    parameter int unsigned WAIT_TIMEOUT = 255
`ifdef HAZARD_PERF_EN
    ,
    parameter int unsigned CNT_W        = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             ex_hold,
    output logic             memwb_bubble,
    output logic             mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam int unsigned CW = $clog2(WAIT_TIMEOUT + 1);
    // Counter value at which the current non-ready cycle is the last allowed one.
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_wait_cnt;
    logic [CW-1:0]   w_wait_cnt_nxt;

    logic            w_load_use;
    logic            w_mem_stall;
    logic            w_freeze;
    logic            w_run_eval;

    assign w_load_use = idex_memread && (idex_rd != 5'd0) &&
                        ((id_uses_rs1 && (idex_rd == id_rs1)) ||
                         (id_uses_rs2 && (idex_rd == id_rs2)));

    // A dropped request while waiting counts as completion, so no extra term.
    assign w_mem_stall = dmem_req && !dmem_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_freeze       = 1'b0;
        w_run_eval     = 1'b0;
        pc_write       = 1'b1;
        ifid_write     = 1'b1;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        ex_hold        = 1'b0;
        memwb_bubble   = 1'b0;
        mem_err        = 1'b0;

        unique case (r_state)
            RUN: begin
                if (w_mem_stall) begin
                    w_freeze       = 1'b1;
                    w_wait_cnt_nxt = CW'(1);
                    // With a timeout of one, the first non-ready cycle already expires it.
                    w_state_nxt    = (WAIT_TIMEOUT <= 1) ? ERR : WAIT;
                end else begin
                    w_run_eval     = 1'b1;
                    w_wait_cnt_nxt = '0;
                end
            end
            WAIT: begin
                if (w_mem_stall) begin
                    w_freeze = 1'b1;
                    if (r_wait_cnt >= LAST_CNT) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + CW'(1);
                    end
                end else begin
                    // Release in the ready cycle itself; pending branch/load-use act now.
                    w_run_eval     = 1'b1;
                    w_state_nxt    = RUN;
                    w_wait_cnt_nxt = '0;
                end
            end
            ERR: begin
                w_freeze = 1'b1;
                mem_err  = 1'b1;
            end
            default: begin
                w_state_nxt    = RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase

        if (w_freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ex_hold      = 1'b1;
            memwb_bubble = 1'b1;
        end else if (w_run_eval) begin
            if (branch_taken) begin
                // Squashing ID makes any simultaneous load-use irrelevant.
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_load_use) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (!rst_n) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            ex_hold      = 1'b0;
            memwb_bubble = 1'b1;
            mem_err      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_events;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_events <= '0;
        end else begin
            if (!pc_write && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            end
            if (ifid_flush && (r_flush_events != '1)) begin
                r_flush_events <= r_flush_events + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl
//   Directed-vector bench for hazard_stall_ctrl. Inputs change 1 ns after the
//   rising edge; the combinational controls are sampled on the falling edge.
//   Control outputs are packed as
//   {pc_write, ifid_write, ifid_flush, idex_flush, ex_hold, memwb_bubble, mem_err}.
//   Perf counter checks are compiled only when HAZARD_PERF_EN is defined.

module tb_hazard_stall_ctrl;

    localparam logic [6:0] C_IDLE = 7'b1100000;
    localparam logic [6:0] C_LU   = 7'b0001000;
    localparam logic [6:0] C_BR   = 7'b1111000;
    localparam logic [6:0] C_FRZ  = 7'b0000110;
    localparam logic [6:0] C_ERR  = 7'b0000111;
    localparam logic [6:0] C_RST  = 7'b0011010;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] idex_rd;
    logic       idex_memread;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_flush;
    logic       ex_hold;
    logic       memwb_bubble;
    logic       mem_err;
`ifdef HAZARD_PERF_EN
    logic [2:0] stall_cycles;
    logic [2:0] flush_events;
`endif

    int unsigned n_cmp;
    int unsigned n_err;

    hazard_stall_ctrl #(
        .WAIT_TIMEOUT(4)
`ifdef HAZARD_PERF_EN
        ,
        .CNT_W(3)
`endif
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .idex_rd      (idex_rd),
        .idex_memread (idex_memread),
        .branch_taken (branch_taken),
        .dmem_req     (dmem_req),
        .dmem_ready   (dmem_ready),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .ex_hold      (ex_hold),
        .memwb_bubble (memwb_bubble),
        .mem_err      (mem_err)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic memread, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic br,
                         input logic req, input logic rdy);
        idex_memread = memread;
        idex_rd      = rd;
        id_rs1       = rs1;
        id_rs2       = rs2;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        branch_taken = br;
        dmem_req     = req;
        dmem_ready   = rdy;
    endtask

    // Check the controls mid-cycle, then advance to just after the next edge.
    task automatic step(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk(tag, 32'({pc_write, ifid_write, ifid_flush, idex_flush,
                      ex_hold, memwb_bubble, mem_err}), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);

        step("reset_a", C_RST);
        step("reset_b", C_RST);
        rst_n = 1'b1;
        step("idle", C_IDLE);

        // Load-use through rs2: exactly one bubble.
        drive(1, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0);
        step("lu_rs2", C_LU);
        drive(0, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0);
        step("lu_rs2_next", C_IDLE);

        // x0 destination and unused operand never stall.
        drive(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        step("lu_x0", C_IDLE);
        drive(1, 5'd7, 5'd7, 5'd3, 0, 1, 0, 0, 0);
        step("lu_unused_rs1", C_IDLE);
        drive(1, 5'd7, 5'd2, 5'd3, 1, 1, 0, 0, 0);
        step("lu_no_match", C_IDLE);
        // Load-use through rs1.
        drive(1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0);
        step("lu_rs1", C_LU);

        // Three-cycle memory wait, released in the ready cycle.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        step("mw_1", C_FRZ);
        step("mw_2", C_FRZ);
        step("mw_3", C_FRZ);
        dmem_ready = 1'b1;
        step("mw_release", C_IDLE);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        step("mw_after", C_IDLE);

        // Branch wins over a simultaneous load-use.
        drive(1, 5'd9, 5'd9, 5'd0, 1, 0, 1, 0, 0);
        step("br_lu", C_BR);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        step("br_after", C_IDLE);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_5", 32'(stall_cycles), 32'd5);
        chk("perf_flush_1", 32'(flush_events), 32'd1);
`endif

        // Branch during a memory stall: freeze first, flushes in the ready cycle.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0);
        step("br_in_stall", C_FRZ);
        dmem_ready = 1'b1;
        step("br_at_ready", C_BR);

        // Dropping the request while waiting releases like ready.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        step("drop_stall", C_FRZ);
        dmem_req = 1'b0;
        step("drop_release", C_IDLE);
        // The next idle cycle adds nothing to either counter.
        step("drop_after", C_IDLE);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_7", 32'(stall_cycles), 32'd7);
        chk("perf_flush_2", 32'(flush_events), 32'd2);
`endif

        // Saturation: one more stall, and seven more flushes.
        drive(1, 5'd4, 5'd4, 5'd0, 1, 0, 0, 0, 0);
        step("lu_sat", C_LU);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) step("br_loop", C_BR);
        branch_taken = 1'b0;
        step("sat_idle", C_IDLE);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_sat", 32'(stall_cycles), 32'd7);
        chk("perf_flush_sat", 32'(flush_events), 32'd7);
`endif

        // Timeout: four non-ready cycles, then sticky error.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
        step("to_1", C_FRZ);
        step("to_2", C_FRZ);
        step("to_3", C_FRZ);
        step("to_4", C_FRZ);
        step("to_err", C_ERR);
        step("to_err_hold", C_ERR);
        dmem_ready = 1'b1;
        step("to_err_ready", C_ERR);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        step("to_err_noreq", C_ERR);

        // One reset edge clears the error.
        rst_n = 1'b0;
        step("err_reset", C_RST);
        rst_n = 1'b1;
        step("post_reset", C_IDLE);
`ifdef HAZARD_PERF_EN
        chk("perf_stall_clr", 32'(stall_cycles), 32'd0);
        chk("perf_flush_clr", 32'(flush_events), 32'd0);
`endif
        // A fresh wait after reset starts counting from zero again.
        dmem_req = 1'b1;
        step("rerun_1", C_FRZ);
        step("rerun_2", C_FRZ);
        step("rerun_3", C_FRZ);
        dmem_ready = 1'b1;
        step("rerun_release", C_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
